// File: rtl/neopixel_pkg.sv
// neopixel_pkg
//   Shared definitions for the WS2812 strip controller:
//   - state_t      : controller FSM states (IDLE, SEND, LATCH)
//   - DEF_*        : default parameter values for a 100 MHz clock
//   - cnt_width()  : register width able to hold the values 0 .. max_count-1
package neopixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int DEF_PX_COUNT_WIDTH = 6;
    localparam int DEF_PX_NUM         = 8;
    localparam int DEF_BITS_PER_PIXEL = 24;
    localparam int DEF_T0H_CYCLES     = 40;    // 0.4 us
    localparam int DEF_T1H_CYCLES     = 80;    // 0.8 us
    localparam int DEF_BIT_CYCLES     = 125;   // 1.25 us
    localparam int DEF_RESET_CYCLES   = 5000;  // 50 us

    // Counters only ever hold 0 .. max_count-1; never return a zero width.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/neopixel_bit_encoder.sv
// neopixel_bit_encoder
//   Produces the waveform of a single WS2812 bit: high for t1h_cycles
//   (bit=1) or t0h_cycles (bit=0), then low until bit_cycles have elapsed.
//   A bit_start arriving on the same edge that bit_done is high chains the
//   next bit with no idle cycle in between.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bit_start  : strobe, starts a new bit at this edge
//   bit_value  : value of the bit started by bit_start
//   level      : registered line level
//   bit_done   : high in the final cycle of a bit period
module neopixel_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int t0h_cycles = DEF_T0H_CYCLES,
    parameter int t1h_cycles = DEF_T1H_CYCLES,
    parameter int bit_cycles = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_start,
    input  logic bit_value,
    output logic level,
    output logic bit_done
);

    localparam int CNT_W = cnt_width(bit_cycles);

    logic             active;
    logic             bit_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] high_len;

    // t1h_cycles < bit_cycles, so both high widths fit the counter width.
    assign high_len = bit_r ? CNT_W'(t1h_cycles) : CNT_W'(t0h_cycles);
    assign bit_done = active && (cnt == CNT_W'(bit_cycles - 1));
    // Only used while cnt < bit_cycles-1, so the increment cannot wrap.
    assign cnt_nxt  = cnt + CNT_W'(1);

    // cnt is the index of the current cycle within the bit; level for the
    // coming cycle is decided one edge ahead so the output stays registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            bit_r  <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else if (bit_start) begin
            active <= 1'b1;
            bit_r  <= bit_value;
            cnt    <= '0;
            level  <= bit_value ? (t1h_cycles != 0) : (t0h_cycles != 0);
        end else if (bit_done) begin
            active <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else if (active) begin
            cnt    <= cnt_nxt;
            level  <= (cnt_nxt < high_len);
        end
    end

endmodule

// File: rtl/neopixel_strip_controller.sv
// neopixel_strip_controller
//   Streams px_num pixels of bits_per_pixel bits (MSB first) to a WS2812
//   chain on start, then holds the line low for reset_cycles to latch.
//   Pixels are fetched from an external combinational framebuffer addressed
//   by next_px_num, one pixel ahead of the one being shifted out.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset (aborts any frame)
//   start       : frame request, honoured only in IDLE
//   pixel       : framebuffer data for index next_px_num (same cycle)
//   next_px_num : registered index of the next pixel to load
//   signal_out  : registered WS2812 data line
module neopixel_strip_controller
    import neopixel_pkg::*;
#(
    parameter int px_count_width = DEF_PX_COUNT_WIDTH,
    parameter int px_num         = DEF_PX_NUM,
    parameter int bits_per_pixel = DEF_BITS_PER_PIXEL,
    parameter int t0h_cycles     = DEF_T0H_CYCLES,
    parameter int t1h_cycles     = DEF_T1H_CYCLES,
    parameter int bit_cycles     = DEF_BIT_CYCLES,
    parameter int reset_cycles   = DEF_RESET_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [bits_per_pixel-1:0] pixel,
    output logic [px_count_width-1:0] next_px_num,
    output logic                      signal_out
);

    localparam int BIT_W = cnt_width(bits_per_pixel);
    localparam int TMR_W = cnt_width(reset_cycles);

    state_t                    state;
    logic [bits_per_pixel-1:0] shreg;
    logic [BIT_W-1:0]          bit_cnt;
    logic [TMR_W-1:0]          timer;

    logic                      enc_start;
    logic                      enc_bit;
    logic                      enc_done;
    logic                      last_bit;
    logic                      last_px;
    logic [bits_per_pixel-1:0] next_word;
    logic [px_count_width-1:0] px_advance;

    assign last_bit = (bit_cnt == BIT_W'(bits_per_pixel - 1));
    // next_px_num wraps to 0 when the final pixel is loaded, so an index of
    // 0 while sending means the pixel on the wire is the last one.
    assign last_px  = (next_px_num == '0);

    // Word whose MSB is the next bit on the wire: a freshly fetched pixel at
    // a pixel boundary, otherwise the shift register moved up by one.
    assign next_word = last_bit ? pixel : (shreg << 1);

    assign px_advance = (next_px_num == px_count_width'(px_num - 1))
                        ? '0 : next_px_num + px_count_width'(1);

    always_comb begin
        enc_start = 1'b0;
        enc_bit   = 1'b0;
        case (state)
            ST_IDLE: begin
                enc_start = start;
                enc_bit   = pixel[bits_per_pixel-1];
            end
            ST_SEND: begin
                if (enc_done && !(last_bit && last_px)) begin
                    enc_start = 1'b1;
                    enc_bit   = next_word[bits_per_pixel-1];
                end
            end
            default: ;
        endcase
    end

    neopixel_bit_encoder #(
        .t0h_cycles (t0h_cycles),
        .t1h_cycles (t1h_cycles),
        .bit_cycles (bit_cycles)
    ) u_bit_encoder (
        .clk       (clk),
        .rst       (rst),
        .bit_start (enc_start),
        .bit_value (enc_bit),
        .level     (signal_out),
        .bit_done  (enc_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            next_px_num <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg       <= pixel;
                        bit_cnt     <= '0;
                        next_px_num <= (px_num == 1) ? '0 : px_count_width'(1);
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (enc_done) begin
                        if (last_bit && last_px) begin
                            bit_cnt <= '0;
                            timer   <= '0;
                            state   <= ST_LATCH;
                        end else begin
                            shreg <= next_word;
                            if (last_bit) begin
                                bit_cnt     <= '0;
                                next_px_num <= px_advance;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (timer == TMR_W'(reset_cycles - 1)) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_strip_controller.sv
// Testbench for neopixel_strip_controller with a small frame geometry:
// 2 pixels x 4 bits, bit period 6, high widths 2/4, latch 20 cycles.
// The expected line level of every cycle is derived from the pixel words
// and the WS2812 bit rules; inputs change and outputs are sampled on the
// falling clock edge.
module tb_neopixel_strip_controller;

    localparam int PXW = 2;
    localparam int PX  = 2;
    localparam int B   = 4;
    localparam int T0  = 2;
    localparam int T1  = 4;
    localparam int BC  = 6;
    localparam int R   = 20;
    localparam int F   = PX * B * BC;   // line cycles per frame

    logic           clk;
    logic           rst;
    logic           start;
    logic [B-1:0]   pixel;
    logic [PXW-1:0] next_px_num;
    logic           signal_out;

    logic [B-1:0]   fb [PX];

    int checks;
    int failures;

    neopixel_strip_controller #(
        .px_count_width (PXW),
        .px_num         (PX),
        .bits_per_pixel (B),
        .t0h_cycles     (T0),
        .t1h_cycles     (T1),
        .bit_cycles     (BC),
        .reset_cycles   (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel       (pixel),
        .next_px_num (next_px_num),
        .signal_out  (signal_out)
    );

    // Combinational framebuffer read.
    assign pixel = (next_px_num == '0) ? fb[0] : fb[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: level in line cycle j (1 = first cycle after start).
    function automatic logic exp_level(input int j, input logic [B-1:0] p0,
                                       input logic [B-1:0] p1);
        int idx, px, b, c;
        logic [B-1:0] w;
        idx = j - 1;
        px  = idx / (B * BC);
        b   = (idx % (B * BC)) / BC;
        c   = idx % BC;
        w   = (px == 0) ? p0 : p1;
        return (c < (w[B-1-b] ? T1 : T0));
    endfunction

    // Reference: index presented while pixel (j-1)/(B*BC) is on the wire.
    function automatic logic [PXW-1:0] exp_index(input int j);
        int px;
        px = (j - 1) / (B * BC);
        return PXW'((px + 1) % PX);
    endfunction

    // Start a frame at the current falling edge and check every line cycle.
    // busy_at: line cycle during which an extra start pulse is driven (-1: none).
    // abort_at: line cycle at which rst is asserted (-1: none).
    task automatic run_frame(input logic [B-1:0] p0, input logic [B-1:0] p1,
                             input int busy_at, input int abort_at);
        fb[0] = p0;
        fb[1] = p1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= F; j++) begin
            if (j > 1) @(negedge clk);
            if (j == busy_at) start = 1'b1;
            else if (j == busy_at + 1) start = 1'b0;
            checks++;
            if (signal_out !== exp_level(j, p0, p1)) begin
                failures++;
                $display("FAIL wave cycle=%0d data=%h_%h got=%b exp=%b",
                         j, p0, p1, signal_out, exp_level(j, p0, p1));
            end
            checks++;
            if (next_px_num !== exp_index(j)) begin
                failures++;
                $display("FAIL index cycle=%0d got=%0d exp=%0d",
                         j, next_px_num, exp_index(j));
            end
            // Framebuffer entries may change once consumed.
            if (j == 2)  fb[0] = ~p0;
            if (j == 26) fb[1] = ~p1;
            if (j == abort_at) begin
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        fb[0] = p0;
        fb[1] = p1;
    endtask

    // Line must stay low (latch then idle) for n cycles.
    task automatic expect_low(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            checks++;
            if (signal_out !== 1'b0 || next_px_num !== '0) begin
                failures++;
                $display("FAIL %s cycle=%0d line=%b idx=%0d exp line=0 idx=0",
                         tag, i, signal_out, next_px_num);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (signal_out !== 1'b0 || next_px_num !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d line=%b idx=%0d exp 0/0",
                         i, signal_out, next_px_num);
            end
        end
        rst   = 1'b1;
        start = 1'b0;
        expect_low(10, "reset_release");
    endtask

    task automatic test_bit_encoding();
        run_frame(4'hA, 4'h5, -1, -1);
        expect_low(R + 3, "after_enc");
    endtask

    task automatic test_index_handshake();
        run_frame(4'h3, 4'hC, -1, -1);
        expect_low(R + 3, "after_idx");
    endtask

    task automatic test_latch();
        logic [B-1:0] q0, q1;
        q0 = B'($urandom);
        q1 = B'($urandom);
        run_frame(4'hF, 4'h0, -1, -1);
        for (int i = 1; i <= R; i++) begin
            @(negedge clk);
            checks++;
            if (signal_out !== 1'b0) begin
                failures++;
                $display("FAIL latch_low cycle=%0d got=%b exp=0", i, signal_out);
            end
            if (i == 9)  start = 1'b1;   // high during latch cycle 10
            if (i == 10) start = 1'b0;
            if (i == R)  start = 1'b1;   // held into first IDLE cycle
        end
        @(negedge clk);
        checks++;
        if (signal_out !== 1'b0) begin
            failures++;
            $display("FAIL latch_idle_cycle got=%b exp=0", signal_out);
        end
        run_frame(q0, q1, -1, -1);
        expect_low(R + 3, "after_latch");
    endtask

    task automatic test_busy_ignore();
        run_frame(4'hA, 4'h5, 7, -1);
        expect_low(R + 3, "after_busy");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            run_frame(B'($urandom), B'($urandom), -1, -1);
            expect_low(R + 1 + int'($urandom_range(0, 3)), "after_rand");
        end
    endtask

    task automatic test_mid_frame_reset();
        // Pixel 1, bit 2, second cycle of that bit.
        run_frame(4'h9, 4'h6, -1, B * BC + 2 * BC + 2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (signal_out !== 1'b0 || next_px_num !== '0) begin
                failures++;
                $display("FAIL midreset cycle=%0d line=%b idx=%0d exp 0/0",
                         i, signal_out, next_px_num);
            end
        end
        rst = 1'b1;
        expect_low(5, "post_reset_idle");
        run_frame(4'hB, 4'h2, -1, -1);
        expect_low(R + 3, "after_fresh");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        fb[0]    = '0;
        fb[1]    = '0;
        test_reset();
        test_bit_encoding();
        test_index_handshake();
        test_latch();
        test_busy_ignore();
        test_random();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
